// File: rtl/param_accum_alu.sv
// Multi-accumulator ALU: single-cycle logic/add ops plus bit-serial popcount ops.
// Build option: define PARAM_ACCUM_ALU_FLAGS_EN to enable the zero/carry flag registers.
module param_accum_alu #(
   parameter  int WIDTH   = 8,
   parameter  int NUM_ACC = 4,
   localparam int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [SEL_W-1:0] acc_sel,
   input  logic [WIDTH-1:0] data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_acc,
   output logic             flag_zero,
   output logic             flag_carry
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);

   if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("param_accum_alu: WIDTH must be in 4..32");
   end
   if (NUM_ACC < 1 || (NUM_ACC & (NUM_ACC - 1)) != 0) begin : g_bad_num_acc
      $error("param_accum_alu: NUM_ACC must be a power of 2");
   end

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   typedef enum logic [2:0] {
      OP_NOTA_XOR_B = 3'b000,
      OP_A_XOR_NOTB = 3'b001,
      OP_NAND       = 3'b010,
      OP_AND        = 3'b011,
      OP_ADD_INC    = 3'b100,
      OP_XNOR       = 3'b101,
      OP_ZEROS_A    = 3'b110,
      OP_POP_DIFF   = 3'b111
   } op_t;

   state_t             state;
   logic [WIDTH-1:0]   acc [NUM_ACC];

   logic [WIDTH-1:0]   lat_a;
   logic [WIDTH-1:0]   lat_b;
   logic               lat_pop_diff;
   logic [SEL_W-1:0]   lat_sel;
   logic [IDX_W-1:0]   bit_idx;
   logic [CNT_W-1:0]   pop_a;
   logic [CNT_W-1:0]   pop_b;

   logic [SEL_W-1:0]   sel_eff;
   logic [WIDTH-1:0]   b_val;
   logic               is_pop_op;
   logic               last_bit;
   logic [CNT_W-1:0]   pop_a_nxt;
   logic [CNT_W-1:0]   pop_b_nxt;
   logic [WIDTH-1:0]   pop_res;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;

   logic               wr_en;
   logic [SEL_W-1:0]   wr_sel;
   logic [WIDTH-1:0]   wr_data;
   logic               wr_carry;

   assign sel_eff   = (NUM_ACC == 1) ? '0 : acc_sel;
   assign b_val     = acc[sel_eff];
   assign in_ready  = (state == IDLE);
   assign is_pop_op = opcode[2] & opcode[1];
   assign last_bit  = (bit_idx == IDX_W'(WIDTH - 1));

   // The final count edge folds in its own bit, so the result uses the next-state counts.
   assign pop_a_nxt = pop_a + CNT_W'(lat_a[bit_idx]);
   assign pop_b_nxt = pop_b + CNT_W'(lat_b[bit_idx]);
   assign pop_res   = WIDTH'(WIDTH) - WIDTH'(pop_a_nxt)
                    + (lat_pop_diff ? WIDTH'(pop_b_nxt) : '0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alu_res   = '0;
      alu_carry = 1'b0;
      case (opcode)
         OP_NOTA_XOR_B: alu_res = (~data) ^ b_val;
         OP_A_XOR_NOTB: alu_res = data ^ (~b_val);
         OP_NAND:       alu_res = ~(data & b_val);
         OP_AND:        alu_res = data & b_val;
         OP_ADD_INC:    {alu_carry, alu_res} = {1'b0, data} + {1'b0, b_val} + (WIDTH + 1)'(1);
         OP_XNOR:       alu_res = ~(data ^ b_val);
         default:       alu_res = '0;
      endcase
   end

   always_comb begin
      wr_en    = 1'b0;
      wr_sel   = sel_eff;
      wr_data  = alu_res;
      wr_carry = 1'b0;
      if (state == IDLE && in_valid && !is_pop_op) begin
         wr_en    = 1'b1;
         wr_carry = alu_carry;
      end else if (state == COUNT && last_bit) begin
         wr_en   = 1'b1;
         wr_sel  = lat_sel;
         wr_data = pop_res;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_acc   <= '0;
         out_valid <= 1'b0;
         bit_idx   <= '0;
         pop_a     <= '0;
         pop_b     <= '0;
         // NOTE: the accumulator array is architecturally visible state, so it is cleared
         // on reset even though that rules out mapping it onto a RAM macro.
         for (int i = 0; i < NUM_ACC; i++) begin
            acc[i] <= '0;
         end
      end else begin
         out_valid <= wr_en;
         if (wr_en) begin
            acc[wr_sel] <= wr_data;
            out_acc     <= wr_data;
         end
         case (state)
            IDLE: begin
               if (in_valid && is_pop_op) begin
                  lat_a        <= data;
                  lat_b        <= b_val;
                  lat_pop_diff <= opcode[0];
                  lat_sel      <= sel_eff;
                  bit_idx      <= '0;
                  pop_a        <= '0;
                  pop_b        <= '0;
                  state        <= COUNT;
               end
            end
            COUNT: begin
               pop_a   <= pop_a_nxt;
               pop_b   <= pop_b_nxt;
               bit_idx <= bit_idx + 1'b1;
               if (last_bit) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PARAM_ACCUM_ALU_FLAGS_EN
   logic zero_q;
   logic carry_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else if (wr_en) begin
         zero_q  <= (wr_data == '0);
         carry_q <= wr_carry;
      end
   end

   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
`else
   logic unused_flag_src;
   assign unused_flag_src = wr_carry;
   assign flag_zero       = 1'b0;
   assign flag_carry      = 1'b0;
`endif

endmodule

// File: tb/tb_param_accum_alu.sv
// Directed bench for param_accum_alu (WIDTH=8, NUM_ACC=4); flag expectations follow
// whether PARAM_ACCUM_ALU_FLAGS_EN is defined for the build.
module tb_param_accum_alu;

   localparam int WIDTH   = 8;
   localparam int NUM_ACC = 4;
`ifdef PARAM_ACCUM_ALU_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       opcode;
   logic [1:0]       acc_sel;
   logic [WIDTH-1:0] data;
   logic             out_valid;
   logic [WIDTH-1:0] out_acc;
   logic             flag_zero;
   logic             flag_carry;

   int n_checks = 0;
   int n_errors = 0;

   param_accum_alu #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .acc_sel    (acc_sel),
      .data       (data),
      .out_valid  (out_valid),
      .out_acc    (out_acc),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic single_op(input string tag, input logic [2:0] op, input logic [1:0] sel,
                            input logic [7:0] d, input logic [7:0] exp_res,
                            input bit exp_z, input bit exp_c);
      in_valid = 1'b1; opcode = op; acc_sel = sel; data = d;
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".acc"}, out_acc, exp_res);
      check({tag, ".zero"}, flag_zero, FL & exp_z);
      check({tag, ".carry"}, flag_carry, FL & exp_c);
      @(negedge clk);
      check({tag, ".pulse_end"}, out_valid, 0);
   endtask

   task automatic pop_op(input string tag, input logic [2:0] op, input logic [1:0] sel,
                         input logic [7:0] d, input logic [7:0] exp_res, input bit hold);
      int busy   = 0;
      int pulses = 0;
      bit done   = 1'b0;
      in_valid = 1'b1; opcode = op; acc_sel = sel; data = d;
      @(negedge clk);
      if (hold) begin
         opcode = 3'b100; data = 8'h11;
      end else begin
         in_valid = 1'b0;
      end
      for (int i = 0; i < 20 && !done; i++) begin
         if (out_valid === 1'b1) begin
            done = 1'b1;
            pulses++;
            in_valid = 1'b0;
            check({tag, ".ready_after"}, in_ready, 1);
            check({tag, ".acc"}, out_acc, exp_res);
            check({tag, ".zero"}, flag_zero, FL & (exp_res == 8'h00));
            check({tag, ".carry"}, flag_carry, 0);
         end else begin
            if (in_ready === 1'b0) busy++;
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      check({tag, ".done"}, done, 1);
      check({tag, ".busy_cycles"}, busy, WIDTH);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
      end
      check({tag, ".pulses"}, pulses, 1);
   endtask

   logic [2:0] chain_op  [6] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b100, 3'b011};
   logic [7:0] chain_d   [6] = '{8'h0F, 8'h33, 8'hFF, 8'hC5, 8'h01, 8'h00};
   logic [7:0] chain_exp [6] = '{8'hF6, 8'h3A, 8'hC5, 8'hFF, 8'h01, 8'h00};
   bit         chain_c   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      int pulses;
      reset = 1'b1; in_valid = 1'b0; opcode = 3'b000; acc_sel = 2'd0; data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst.ready", in_ready, 1);
      check("rst.valid", out_valid, 0);
      check("rst.acc", out_acc, 8'h00);
      check("rst.zero", flag_zero, 0);
      check("rst.carry", flag_carry, 0);

      single_op("add_first", 3'b100, 2'd0, 8'h05, 8'h06, 1'b0, 1'b0);
      single_op("add_wrap", 3'b100, 2'd1, 8'hFF, 8'h00, 1'b1, 1'b1);
      pop_op("zeros_a", 3'b110, 2'd2, 8'h0F, 8'h04, 1'b0);
      single_op("set_acc3", 3'b100, 2'd3, 8'h02, 8'h03, 1'b0, 1'b0);
      pop_op("pop_diff_hold", 3'b111, 2'd3, 8'hFF, 8'h02, 1'b1);

      // Two accepted ops on consecutive edges, different accumulators.
      in_valid = 1'b1; opcode = 3'b100; acc_sel = 2'd2; data = 8'h01;
      @(negedge clk);
      check("b2b.first_valid", out_valid, 1);
      check("b2b.first_acc", out_acc, 8'h06);
      opcode = 3'b011; acc_sel = 2'd3; data = 8'hF0;
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b.second_valid", out_valid, 1);
      check("b2b.second_acc", out_acc, 8'h00);
      check("b2b.second_zero", flag_zero, FL);
      @(negedge clk);
      check("b2b.end", out_valid, 0);
      single_op("acc2_held", 3'b011, 2'd2, 8'hFF, 8'h06, 1'b0, 1'b0);

      // Dependent chain on acc0: each op reads the previous edge's write.
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; opcode = chain_op[i]; acc_sel = 2'd0; data = chain_d[i];
         @(negedge clk);
         check($sformatf("chain%0d.valid", i), out_valid, 1);
         check($sformatf("chain%0d.acc", i), out_acc, chain_exp[i]);
         check($sformatf("chain%0d.zero", i), flag_zero, FL & (chain_exp[i] == 8'h00));
         check($sformatf("chain%0d.carry", i), flag_carry, FL & chain_c[i]);
      end
      in_valid = 1'b0;
      @(negedge clk);

      single_op("pre_rst_acc0", 3'b100, 2'd0, 8'h40, 8'h41, 1'b0, 1'b0);

      // Reset lands during the 3rd COUNT cycle of an in-flight popcount op.
      in_valid = 1'b1; opcode = 3'b110; acc_sel = 2'd1; data = 8'hAA;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst.ready", in_ready, 1);
      check("midrst.valid", out_valid, 0);
      check("midrst.acc", out_acc, 8'h00);
      check("midrst.zero", flag_zero, 0);
      check("midrst.carry", flag_carry, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
      end
      check("midrst.no_pulse", pulses, 0);
      for (int s = 0; s < NUM_ACC; s++) begin
         single_op($sformatf("midrst.acc%0d", s), 3'b100, 2'(s), 8'h00, 8'h01, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/param_accum_alu.md
PARAM_ACCUM_ALU -- requirements
Module: param_accum_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data and accumulator width; legal range 4..32.
REQ-002 The block SHALL have parameter NUM_ACC, default 4, meaning the number of independent accumulators; power of 2, at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state updated on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset; clock clk.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept an operation this cycle.
REQ-007 The block SHALL have port opcode, input, 3 bits: operation select.
REQ-008 The block SHALL have port acc_sel, input, max(1,$clog2(NUM_ACC)) bits: target accumulator; ignored when NUM_ACC=1.
REQ-009 The block SHALL have port data, input, WIDTH bits: operand A.
REQ-010 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse, result written.
REQ-011 The block SHALL have port out_acc, output, WIDTH bits: most recently written result.
REQ-012 The block SHALL have ports flag_zero and flag_carry, outputs, 1 bit each: result flags.

Function
REQ-013 An operation SHALL be accepted on a rising edge with in_valid=1 and in_ready=1, with A=data and B=acc[acc_sel] at that edge.
REQ-014 The opcodes SHALL be: 000 (~A)^B; 001 A^(~B); 010 ~(A&B); 011 A&B; 100 A+B+1; 101 ~(A^B); 110 WIDTH-pop(A); 111 pop(B)+WIDTH-pop(A).
REQ-015 All results SHALL be truncated modulo 2^WIDTH.
REQ-016 The FSM SHALL have states IDLE and COUNT; in_ready=1 exactly in IDLE.
REQ-017 Opcodes 000-101 SHALL be single-cycle: at the accepting edge, acc[acc_sel] and out_acc get the result, the state stays IDLE, and out_valid=1 for the following cycle only.
REQ-018 Back-to-back single-cycle operations SHALL be accepted every cycle, with B reading the value written by the previous edge.
REQ-019 Opcodes 110/111 SHALL latch A, B, the opcode and acc_sel at the accepting edge, clear the bit index and both popcounts, and enter COUNT.
REQ-020 In COUNT, each edge SHALL add bit[index] of latched A and of latched B to their popcounts and increment the index.
REQ-021 COUNT SHALL span exactly WIDTH edges; an op accepted at edge k writes acc, out_acc and the flags at edge k+WIDTH, pulses out_valid in the cycle after, and returns to IDLE at k+WIDTH.
REQ-022 While in COUNT, in_valid SHALL be ignored; the operation is not captured or queued.
REQ-023 Only the selected accumulator SHALL change on a write; the others hold.
REQ-024 flag_zero SHALL be 1 when the written result is 0.
REQ-025 flag_carry SHALL be the carry out of bit WIDTH-1 for opcode 100, and 0 for all other opcodes.
REQ-026 The flags SHALL update only with out_acc.

Reset
REQ-027 When reset=1 at a rising edge, all accumulators, out_acc, out_valid, flag_zero, flag_carry, the popcounts and the index SHALL clear to 0, and the state SHALL become IDLE.
REQ-028 Reset SHALL take priority over acceptance and over COUNT; an in-flight popcount op is discarded with no write and no out_valid.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 Macro PARAM_ACCUM_ALU_FLAGS_EN SHALL control the flag logic.
REQ-031 When PARAM_ACCUM_ALU_FLAGS_EN is defined, the flag logic SHALL be per REQ-024..026.
REQ-032 When it is undefined, flag_zero and flag_carry SHALL be tied to 0, no flag registers exist, and all other behaviour is unchanged.

Verification (WIDTH=8, NUM_ACC=4, FLAGS_EN defined)
REQ-033 After reset, opcode 100, data=0x05, acc_sel=0 -> acc0=0x06, out_acc=0x06, out_valid high exactly one cycle, zero=0, carry=0.
REQ-034 Accept opcode 100, data=0xFF on acc1=0x00 -> out_acc=0x00, flag_zero=1, flag_carry=1.
REQ-035 Opcode 110, data=0x0F, acc_sel=2, accepted at edge k -> in_ready=0 for 8 cycles, acc2=0x04 at edge k+8, out_valid pulses once, then in_ready=1.
REQ-036 acc3=0x03, then opcode 111, data=0xFF, acc_sel=3 -> result 0x02; in_valid held high throughout COUNT captures nothing extra (exactly one out_valid).
REQ-037 Write acc2=0x06 via 100, then opcode 011, data=0xF0, acc_sel=3 on consecutive cycles -> acc3=0x00, acc2 stays 0x06, two consecutive out_valid pulses.
REQ-038 Reset asserted in the 3rd COUNT cycle -> no out_valid, all accumulators and out_acc = 0x00, in_ready=1 in the first cycle after reset deasserts.
